// File: rtl/multi_ch_debouncer_if.sv
// Bundle of the debouncer's data/control signals, grouped so that the
// driver (switch side / control side) and the debouncer each see the right directions.
interface multi_ch_debouncer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) ();
  logic [NUM_CH-1:0] noisy_IN;
  logic              en;
  logic [CNT_W-1:0]  delay_cfg;
  logic [NUM_CH-1:0] deb_out;
  logic [NUM_CH-1:0] rise_pls;
  logic [NUM_CH-1:0] fall_pls;
  logic [NUM_CH-1:0] busy;

  modport master (
    output noisy_IN, en, delay_cfg,
    input  deb_out, rise_pls, fall_pls, busy
  );

  modport slave (
    input  noisy_IN, en, delay_cfg,
    output deb_out, rise_pls, fall_pls, busy
  );
endinterface

// File: rtl/multi_ch_debouncer.sv
// N-channel delay-detection debouncer.
// Each channel: bit synchroniser -> confirm FSM with a private up-counter.
// A level change on the synchronised input must persist for D consecutive
// enabled cycles before deb_out follows it; any bounce restarts the wait.
//
// state      | meaning
// ST_STABLE  | synchronised input matches deb_out, nothing pending
// ST_CONFIRM | input differs from deb_out, counting towards the latched delay
module multi_ch_debouncer #(
  parameter int   NUM_CH      = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter int   DEF_DELAY   = 100,
  parameter logic RST_VAL     = 1'b0
) (
  input logic                  CLK,
  input logic                  RST,
  multi_ch_debouncer_if.slave  bus
);

  localparam logic [0:0]       ST_STABLE  = 1'b0;
  localparam logic [0:0]       ST_CONFIRM = 1'b1;
  localparam logic [CNT_W-1:0] DEF_D      = CNT_W'(DEF_DELAY);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
  logic [CNT_W-1:0]       cnt_q  [NUM_CH];
  logic [CNT_W-1:0]       cnt_d  [NUM_CH];
  logic [CNT_W-1:0]       dlat_q [NUM_CH];
  logic [CNT_W-1:0]       dlat_d [NUM_CH];
  logic [NUM_CH-1:0]      state_q, state_d;
  logic [NUM_CH-1:0]      deb_q, deb_d;
  logic [NUM_CH-1:0]      rise_q, rise_d;
  logic [NUM_CH-1:0]      fall_q, fall_d;
  logic [NUM_CH-1:0]      sync_s;
  logic [CNT_W-1:0]       eff_delay;

  // Synchroniser next-state (always shifting, independent of en) and its last stage.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], bus.noisy_IN[ch]};
      sync_s[ch] = sync_q[ch][SYNC_STAGES-1];
    end
  end

  // Per-channel confirm FSM; a delay of 1 toggles straight from STABLE.
  always_comb begin
    eff_delay = (bus.delay_cfg == '0) ? DEF_D : bus.delay_cfg;
    state_d   = state_q;
    deb_d     = deb_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch]  = cnt_q[ch];
      dlat_d[ch] = dlat_q[ch];
      if (bus.en) begin
        case (state_q[ch])
          ST_STABLE: begin
            if (sync_s[ch] != deb_q[ch]) begin
              dlat_d[ch] = eff_delay;
              if (eff_delay == ONE) begin
                deb_d[ch]  = sync_s[ch];
                rise_d[ch] = sync_s[ch];
                fall_d[ch] = ~sync_s[ch];
              end else begin
                state_d[ch] = ST_CONFIRM;
                cnt_d[ch]   = ONE;
              end
            end
          end
          ST_CONFIRM: begin
            if (sync_s[ch] == deb_q[ch]) begin
              state_d[ch] = ST_STABLE;
              cnt_d[ch]   = '0;
            end else if (cnt_q[ch] == dlat_q[ch] - ONE) begin
              deb_d[ch]   = sync_s[ch];
              rise_d[ch]  = sync_s[ch];
              fall_d[ch]  = ~sync_s[ch];
              state_d[ch] = ST_STABLE;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch] = cnt_q[ch] + ONE;
            end
          end
          default: begin
            state_d[ch] = ST_STABLE;
            cnt_d[ch]   = '0;
          end
        endcase
      end
    end
  end

  // State registers with asynchronous reset; reset aborts any pending confirm.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= {SYNC_STAGES{RST_VAL}};
        cnt_q[ch]  <= '0;
        dlat_q[ch] <= '0;
      end
      state_q <= {NUM_CH{ST_STABLE}};
      deb_q   <= {NUM_CH{RST_VAL}};
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= sync_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
        dlat_q[ch] <= dlat_d[ch];
      end
      state_q <= state_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Output mapping; busy comes straight from the registered state.
  always_comb begin
    bus.deb_out  = deb_q;
    bus.rise_pls = rise_q;
    bus.fall_pls = fall_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bus.busy[ch] = (state_q[ch] == ST_CONFIRM);
    end
  end

endmodule

// File: tb/tb_multi_ch_debouncer.sv
// Bench for multi_ch_debouncer: a run-length reference model pushes the expected
// outputs each clock, a monitor pops and compares them; directed latency checks
// cover the documented timing points.
module tb_multi_ch_debouncer;
  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int CW   = 8;
  localparam int DEFD = 100;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  multi_ch_debouncer_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  multi_ch_debouncer #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .CNT_W(CW), .DEF_DELAY(DEFD), .RST_VAL(1'b0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: input seen SYNC edges late; deb follows once the
  // mismatch has lasted D enabled cycles, D taken at the start of the run.
  bit   m_hist [NCH][SYNC];
  bit   m_deb  [NCH];
  int   m_run  [NCH];
  int   m_dl   [NCH];
  logic [4*NCH-1:0] exp_q [$];

  always @(posedge CLK) begin
    logic [NCH-1:0] e_deb, e_rise, e_fall, e_busy;
    int eff;
    bit s;
    e_rise = '0;
    e_fall = '0;
    eff = (bus.delay_cfg == 0) ? DEFD : int'(bus.delay_cfg);
    for (int ch = 0; ch < NCH; ch++) begin
      if (RST) begin
        for (int k = 0; k < SYNC; k++) m_hist[ch][k] = 1'b0;
        m_deb[ch] = 1'b0;
        m_run[ch] = 0;
        m_dl[ch]  = 0;
      end else begin
        s = m_hist[ch][SYNC-1];
        if (bus.en) begin
          if (s != m_deb[ch]) begin
            if (m_run[ch] == 0) m_dl[ch] = eff;
            m_run[ch]++;
            if (m_run[ch] == m_dl[ch]) begin
              m_deb[ch]  = s;
              e_rise[ch] = s;
              e_fall[ch] = !s;
              m_run[ch]  = 0;
            end
          end else begin
            m_run[ch] = 0;
          end
        end
        for (int k = SYNC-1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
        m_hist[ch][0] = bus.noisy_IN[ch];
      end
      e_deb[ch]  = m_deb[ch];
      e_busy[ch] = (m_run[ch] != 0);
    end
    exp_q.push_back({e_deb, e_rise, e_fall, e_busy});
  end

  // Monitor: compare DUT outputs 1 time unit after every rising edge.
  always @(posedge CLK) begin
    logic [4*NCH-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.deb_out, bus.rise_pls, bus.fall_pls, bus.busy};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outputs: got deb=%h rise=%h fall=%h busy=%h expected deb=%h rise=%h fall=%h busy=%h at %0t",
                 a[15:12], a[11:8], a[7:4], a[3:0], e[15:12], e[11:8], e[7:4], e[3:0], $time);
      end
    end
  end

  // Count rising edges until deb_out[ch]==lvl; returns the edge count (limit+1 on timeout).
  task automatic edges_until(input int ch, input bit lvl, input int limit, output int n);
    n = 0;
    forever begin
      @(posedge CLK);
      n++;
      #1;
      if (bus.deb_out[ch] == lvl) break;
      if (n >= limit) begin
        n = limit + 1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [NCH-1:0] rise_seen;
    bus.noisy_IN  = '0;
    bus.en        = 1'b1;
    bus.delay_cfg = '0;
    repeat (3) @(negedge CLK);
    chk("reset_deb", int'(bus.deb_out), 0);
    RST = 1'b0;

    // Quiet after reset.
    repeat (50) @(negedge CLK);
    chk("idle_deb", int'(bus.deb_out), 0);

    // ch0 rise with delay 10.
    bus.delay_cfg = 8'd10;
    bus.noisy_IN[0] = 1'b1;
    edges_until(0, 1'b1, 200, n);
    chk("ch0_rise_edge", n, 12);
    chk("ch0_rise_pls", int'(bus.rise_pls[0]), 1);
    @(negedge CLK);
    repeat (20) @(negedge CLK);

    // ch1 chatter then settle high.
    for (int i = 0; i < 10; i++) begin
      bus.noisy_IN[1] = ~bus.noisy_IN[1];
      repeat (4) @(negedge CLK);
    end
    chk("ch1_no_change", int'(bus.deb_out[1]), 0);
    bus.noisy_IN[1] = 1'b1;
    edges_until(1, 1'b1, 200, n);
    chk("ch1_rise_edge", n, 12);
    @(negedge CLK);

    // ch2 fall with default delay; delay_cfg change mid-confirm ignored.
    bus.noisy_IN[2] = 1'b1;
    repeat (20) @(negedge CLK);
    bus.delay_cfg = '0;
    bus.noisy_IN[2] = 1'b0;
    n = 0;
    forever begin
      @(posedge CLK);
      n++;
      #1;
      if (n == 20) bus.delay_cfg = 8'd5;
      if (bus.deb_out[2] == 1'b0 || n >= 300) break;
    end
    chk("ch2_fall_edge", n, 102);
    chk("ch2_fall_pls", int'(bus.fall_pls[2]), 1);
    @(negedge CLK);
    bus.delay_cfg = 8'd10;
    repeat (5) @(negedge CLK);

    // ch3 frozen by en=0 at cnt=6.
    bus.noisy_IN[3] = 1'b1;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    bus.en = 1'b0;
    repeat (20) @(negedge CLK);
    chk("ch3_frozen", int'(bus.deb_out[3]), 0);
    bus.en = 1'b1;
    edges_until(3, 1'b1, 50, n);
    chk("ch3_resume_edge", n, 4);
    @(negedge CLK);
    repeat (5) @(negedge CLK);

    // ch3 fall aborted by reset at cnt=6.
    bus.noisy_IN[3] = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_abort_deb", int'(bus.deb_out), 0);
    chk("rst_abort_fall", int'(bus.fall_pls), 0);
    chk("rst_abort_busy", int'(bus.busy), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);

    // All channels step together with delay 1.
    bus.noisy_IN = '0;
    repeat (20) @(negedge CLK);
    bus.delay_cfg = 8'd1;
    bus.noisy_IN = 4'hF;
    n = 0;
    rise_seen = '0;
    forever begin
      @(posedge CLK);
      n++;
      #1;
      if (bus.deb_out == 4'hF || n >= 50) begin
        rise_seen = bus.rise_pls;
        break;
      end
    end
    chk("all_rise_edge", n, 3);
    chk("all_rise_pls", int'(rise_seen), 15);
    @(negedge CLK);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RST = 1'b0;
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, 7) == 0) bus.noisy_IN[ch] = ~bus.noisy_IN[ch];
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) bus.delay_cfg = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 499) == 0) RST = 1'b1;
    end
    @(negedge CLK);
    RST = 1'b0;
    bus.en = 1'b1;
    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
